// File: rtl/aes_inv_round_sequencer.sv
// Round sequencer for the AES inverse cipher: fetches round keys Nr..0 and issues one datapath step per round.
// Optional AES_KEYLEN_SEL_EN adds a key_len input that selects Nr = 10/12/14; otherwise Nr is fixed at 14.
module aes_inv_round_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       rk_valid,
    input  logic       step_done,
`ifdef AES_KEYLEN_SEL_EN
    input  logic [1:0] key_len,
`endif
    output logic       rk_req,
    output logic [3:0] rk_idx,
    output logic       step,
    output logic [1:0] op,
    output logic [3:0] round,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] NR_MAX = 4'd14;

    localparam logic [1:0] OP_ADD_KEY = 2'b00;
    localparam logic [1:0] OP_FULL    = 2'b01;
    localparam logic [1:0] OP_FINAL   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DONE
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       step_q,  step_d;
    logic [3:0] nr_sel;

`ifdef AES_KEYLEN_SEL_EN
    logic [3:0] nr_q, nr_d;

    always_comb begin
        case (key_len)
            2'b00:   nr_sel = 4'd10;
            2'b01:   nr_sel = 4'd12;
            default: nr_sel = 4'd14;
        endcase
    end
`else
    logic [3:0] nr_q;

    assign nr_sel = NR_MAX;
    assign nr_q   = NR_MAX;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values of its peers regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            step_q  <= step_d;
        end
    end

`ifdef AES_KEYLEN_SEL_EN
    // Nr is latched only on an accepted start so later key_len changes cannot disturb a run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nr_q <= NR_MAX;
        end else begin
            nr_q <= nr_d;
        end
    end
`endif

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        step_d  = 1'b0;
`ifdef AES_KEYLEN_SEL_EN
        nr_d    = nr_q;
`endif
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            round_d = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d = S_FETCH;
                        round_d = nr_sel;
`ifdef AES_KEYLEN_SEL_EN
                        nr_d    = nr_sel;
`endif
                    end
                end
                S_FETCH: begin
                    if (rk_valid) begin
                        state_d = S_EXEC;
                        step_d  = 1'b1;
                    end
                end
                S_EXEC: begin
                    if (step_done) begin
                        if (round_q == 4'd0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_FETCH;
                            round_d = round_q - 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    round_d = 4'd0;
                end
            endcase
        end
    end

    // op is only meaningful in EXEC; elsewhere it rests at AddRoundKey (the reset value).
    always_comb begin
        op = OP_ADD_KEY;
        if (state_q == S_EXEC) begin
            if (round_q == nr_q) begin
                op = OP_ADD_KEY;
            end else if (round_q == 4'd0) begin
                op = OP_FINAL;
            end else begin
                op = OP_FULL;
            end
        end
    end

    assign rk_req = (state_q == S_FETCH);
    assign rk_idx = round_q;
    assign round  = round_q;
    assign step   = step_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_aes_inv_round_sequencer.sv
// Directed bench for aes_inv_round_sequencer: a cycle-level reference model checked every cycle,
// plus per-run literal expectations (key order, op mix, step count, latency).
module tb_aes_inv_round_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       rk_valid;
    logic       step_done;
    logic       rk_req;
    logic [3:0] rk_idx;
    logic       step;
    logic [1:0] op;
    logic [3:0] round;
    logic       busy;
    logic       done;
`ifdef AES_KEYLEN_SEL_EN
    logic [1:0] key_len;
`endif

    aes_inv_round_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .rk_valid  (rk_valid),
        .step_done (step_done),
`ifdef AES_KEYLEN_SEL_EN
        .key_len   (key_len),
`endif
        .rk_req    (rk_req),
        .rk_idx    (rk_idx),
        .step      (step),
        .op        (op),
        .round     (round),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: what the sequencer is doing, by activity ----------------
    localparam int A_IDLE = 0, A_WAIT_KEY = 1, A_ROUND = 2, A_FINISH = 3;
    int m_act;
    int m_round;
    int m_nr;
    bit m_step;

    function automatic int nr_for_start();
`ifdef AES_KEYLEN_SEL_EN
        return (key_len == 2'b00) ? 10 : (key_len == 2'b01) ? 12 : 14;
`else
        return 14;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act   = A_IDLE;
            m_round = 0;
            m_nr    = 14;
            m_step  = 0;
        end else begin
            m_step = 0;
            if (m_act != A_IDLE && abort) begin
                m_act   = A_IDLE;
                m_round = 0;
            end else if (m_act == A_IDLE) begin
                if (start && !abort) begin
                    m_nr    = nr_for_start();
                    m_round = m_nr;
                    m_act   = A_WAIT_KEY;
                end
            end else if (m_act == A_WAIT_KEY) begin
                if (rk_valid) begin
                    m_act  = A_ROUND;
                    m_step = 1;
                end
            end else if (m_act == A_ROUND) begin
                if (step_done) begin
                    if (m_round == 0) m_act = A_FINISH;
                    else begin
                        m_round = m_round - 1;
                        m_act   = A_WAIT_KEY;
                    end
                end
            end else begin
                m_act = A_IDLE;
            end
        end
    end

    // ---------------- run statistics gathered from the DUT ----------------
    int cyc = 0;
    int first_fetch;
    int done_cyc;
    int n_steps, n_done, n_op00, n_op01, n_op10, n_fetch7;
    int idx_q[$];

    always @(posedge clk) cyc++;

    task automatic clear_stats();
        first_fetch = -1;
        done_cyc    = -1;
        n_steps = 0; n_done = 0; n_op00 = 0; n_op01 = 0; n_op10 = 0; n_fetch7 = 0;
        idx_q.delete();
    endtask

    // Compare process: model vs DUT on every falling edge, then collect statistics.
    always @(negedge clk) begin
        int exp_op;
        check("busy",   16'(busy),   16'(m_act != A_IDLE));
        check("rk_req", 16'(rk_req), 16'(m_act == A_WAIT_KEY));
        check("rk_idx", 16'(rk_idx), 16'(m_round));
        check("round",  16'(round),  16'(m_round));
        check("step",   16'(step),   16'(m_step));
        check("done",   16'(done),   16'(m_act == A_FINISH));
        if (m_act == A_ROUND) begin
            exp_op = (m_round == m_nr) ? 0 : (m_round == 0) ? 2 : 1;
            check("op", 16'(op), 16'(exp_op));
        end
        if (rk_req && first_fetch < 0) first_fetch = cyc;
        if (rk_req && rk_idx == 4'd7) n_fetch7++;
        if (step) begin
            n_steps++;
            idx_q.push_back(int'(rk_idx));
            if (op == 2'b00) n_op00++;
            if (op == 2'b01) n_op01++;
            if (op == 2'b10) n_op10++;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (n_done == 0 && k < 200) begin
            tick();
            k++;
        end
        check(name, 16'(n_done > 0), 16'd1);
    endtask

    task automatic wait_fetch_idx(input string name, input int idx);
        int k = 0;
        while (!(rk_req && int'(rk_idx) == idx) && k < 200) begin
            tick();
            k++;
        end
        check(name, 16'(rk_req && int'(rk_idx) == idx), 16'd1);
    endtask

    task automatic wait_step_round(input string name, input int r);
        int k = 0;
        while (!(step && int'(round) == r) && k < 200) begin
            tick();
            k++;
        end
        check(name, 16'(step && int'(round) == r), 16'd1);
    endtask

    // Literal expectations for one complete run of Nr+1 rounds.
    task automatic expect_full_run(input string name, input int nr, input int cycles);
        check({name, "_steps"}, 16'(n_steps), 16'(nr + 1));
        check({name, "_op00"},  16'(n_op00),  16'd1);
        check({name, "_op01"},  16'(n_op01),  16'(nr - 1));
        check({name, "_op10"},  16'(n_op10),  16'd1);
        check({name, "_ndone"}, 16'(n_done),  16'd1);
        check({name, "_lat"},   16'(done_cyc - first_fetch + 1), 16'(cycles));
        check({name, "_nidx"},  16'(idx_q.size()), 16'(nr + 1));
        for (int i = 0; i < idx_q.size() && i <= nr; i++)
            check({name, "_idx"}, 16'(idx_q[i]), 16'(nr - i));
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        rk_valid  = 1'b0;
        step_done = 1'b0;
`ifdef AES_KEYLEN_SEL_EN
        key_len   = 2'b10;
`endif
        clear_stats();
        #13;
        check("rst_busy",  16'(busy),   16'd0);
        check("rst_round", 16'(round),  16'd0);
        check("rst_rkreq", 16'(rk_req), 16'd0);
        check("rst_op",    16'(op),     16'd0);
        check("rst_done",  16'(done),   16'd0);
        tick();
        rst_n = 1'b1;

        // Zero-latency responses, Nr = 14.
        rk_valid  = 1'b1;
        step_done = 1'b1;
        tick();
        clear_stats();
        pulse_start();
        check("a_first_idx", 16'(rk_idx), 16'd14);
        wait_done("a_done_seen");
        expect_full_run("a", 14, 31);

        // Key delayed three cycles at round 7.
        tick();
        clear_stats();
        pulse_start();
        wait_fetch_idx("b_reach7", 7);
        rk_valid = 1'b0;
        repeat (3) tick();
        rk_valid = 1'b1;
        wait_done("b_done_seen");
        check("b_fetch7", 16'(n_fetch7), 16'd4);
        expect_full_run("b", 14, 34);

        // Start re-pulsed at round 5 is ignored.
        tick();
        clear_stats();
        pulse_start();
        wait_fetch_idx("c_reach5", 5);
        pulse_start();
        wait_done("c_done_seen");
        repeat (3) tick();
        expect_full_run("c", 14, 31);
        check("c_idle", 16'(busy), 16'd0);

        // Abort together with step_done at round 1.
        clear_stats();
        pulse_start();
        wait_step_round("d_reach1", 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("d_busy",  16'(busy),  16'd0);
        check("d_round", 16'(round), 16'd0);
        repeat (4) tick();
        check("d_ndone", 16'(n_done),  16'd0);
        check("d_steps", 16'(n_steps), 16'd14);
        // Abort and start together in IDLE leave the block idle.
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("d_abort_start", 16'(busy), 16'd0);
        clear_stats();
        pulse_start();
        check("d_restart_idx", 16'(rk_idx), 16'd14);
        wait_done("d_done_seen");
        expect_full_run("d", 14, 31);

        // Reset asserted mid-sequence, in EXEC at round 9.
        tick();
        clear_stats();
        pulse_start();
        wait_step_round("e_reach9", 9);
        #2 rst_n = 1'b0;
        #1;
        check("e_busy",   16'(busy),   16'd0);
        check("e_round",  16'(round),  16'd0);
        check("e_rkidx",  16'(rk_idx), 16'd0);
        check("e_step",   16'(step),   16'd0);
        check("e_op",     16'(op),     16'd0);
        check("e_done",   16'(done),   16'd0);
        check("e_rkreq",  16'(rk_req), 16'd0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        repeat (5) tick();
        check("e_ndone", 16'(n_done), 16'd0);
        check("e_idle",  16'(busy),   16'd0);
        // Start on the very first edge after release.
        tick();
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        clear_stats();
        pulse_start();
        check("e_first_busy",  16'(busy),  16'd1);
        check("e_first_round", 16'(round), 16'd14);
        wait_done("e_done_seen");
        expect_full_run("e", 14, 31);

`ifdef AES_KEYLEN_SEL_EN
        // AES-128 selected at start; key_len changed mid-run must not matter.
        tick();
        clear_stats();
        key_len = 2'b00;
        pulse_start();
        check("f_first_idx", 16'(rk_idx), 16'd10);
        repeat (4) tick();
        key_len = 2'b10;
        wait_done("f_done_seen");
        expect_full_run("f", 10, 23);
`endif

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
